// File: rtl/nyq_fir_mc.sv
// rtl/nyq_fir_mc.sv - multi-channel time-multiplexed Nyquist FIR with one MAC and writable coefficients
module nyq_fir_mc #(
    parameter int IN_WIDTH   = 24,
    parameter int COEF_WIDTH = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int FRAC_BITS  = 22,
    parameter int NUM_TAPS   = 16,
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 11,
    parameter int CH_BITS    = 1
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [COEF_WIDTH-1:0] PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   In_DI,
    input  logic [CH_BITS-1:0]    InCh_DI,
    input  logic                  InValid_SI,
    output logic                  InReady_SO,
    output logic [OUT_WIDTH-1:0]  Out_DO,
    output logic [CH_BITS-1:0]    OutCh_DO,
    output logic                  OutValid_SO
);
    localparam int K_BITS    = $clog2(NUM_TAPS);
    localparam int PW        = IN_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH = PW + $clog2(NUM_TAPS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [ACC_WIDTH-1:0] RND_HALF =
        {{(ACC_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [1:0]                   state_q, state_d;
    logic [K_BITS-1:0]            k_q, k_d;
    logic [CH_BITS-1:0]           ch_q, ch_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [OUT_WIDTH-1:0]         r_q, r_d;
    logic [OUT_WIDTH-1:0]         out_q, out_d;
    logic [CH_BITS-1:0]           outch_q, outch_d;
    logic                         outvalid_q, outvalid_d;

    logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
    logic signed [IN_WIDTH-1:0]   x_q    [NUM_CH][NUM_TAPS];

    logic                         idle, sample_take, ch_ok, coef_we, flush;
    logic signed [IN_WIDTH-1:0]   x_cur;
    logic signed [COEF_WIDTH-1:0] c_cur;
    logic signed [PW-1:0]         x_ext, c_ext, prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext, rnd, shf;

    assign idle        = (state_q == S_IDLE);
    assign InReady_SO  = idle;
    assign ch_ok       = (32'(InCh_DI) < NUM_CH);
    assign sample_take = idle && InValid_SI && ch_ok;
    assign coef_we     = idle && WrEn_SI && (32'(Addr_DI) < NUM_TAPS);
    assign flush       = idle && WrEn_SI && (Addr_DI == '1);

    // Full-precision signed product, operands widened explicitly before the multiply
    assign x_cur    = x_q[ch_q][k_q];
    assign c_cur    = coef_q[k_q];
    assign x_ext    = {{COEF_WIDTH{x_cur[IN_WIDTH-1]}}, x_cur};
    assign c_ext    = {{IN_WIDTH{c_cur[COEF_WIDTH-1]}}, c_cur};
    assign prod     = x_ext * c_ext;
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign rnd      = acc_q + RND_HALF;
    assign shf      = rnd >>> FRAC_BITS;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ch_d       = ch_q;
        acc_d      = acc_q;
        r_d        = r_q;
        out_d      = out_q;
        outch_d    = outch_q;
        outvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_take) begin
                    ch_d    = InCh_DI;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                k_d   = k_q + 1'b1;
                if (k_q == K_BITS'(NUM_TAPS-1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                if (shf > SAT_MAX)      r_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                else if (shf < SAT_MIN) r_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                else                    r_d = shf[OUT_WIDTH-1:0];
                state_d = S_OUT;
            end
            default: begin
                out_d      = r_q;
                outch_d    = ch_q;
                outvalid_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            ch_q       <= '0;
            acc_q      <= '0;
            r_q        <= '0;
            out_q      <= '0;
            outch_q    <= '0;
            outvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ch_q       <= ch_d;
            acc_q      <= acc_d;
            r_q        <= r_d;
            out_q      <= out_d;
            outch_q    <= outch_d;
            outvalid_q <= outvalid_d;
        end
    end

    // A flush coinciding with a sample leaves only the new sample in that line
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int t = 0; t < NUM_TAPS; t++) coef_q[t] <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int t = 0; t < NUM_TAPS; t++) x_q[c][t] <= '0;
        end else begin
            if (coef_we) coef_q[Addr_DI[K_BITS-1:0]] <= PAR_In_DI;
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush)
                    for (int t = 0; t < NUM_TAPS; t++) x_q[c][t] <= '0;
                if (sample_take && (32'(InCh_DI) == c)) begin
                    x_q[c][0] <= In_DI;
                    for (int t = 1; t < NUM_TAPS; t++)
                        x_q[c][t] <= flush ? '0 : x_q[c][t-1];
                end
            end
        end
    end

    assign Out_DO      = out_q;
    assign OutCh_DO    = outch_q;
    assign OutValid_SO = outvalid_q;
endmodule

// File: tb/tb_nyq_fir_mc.sv
// tb/tb_nyq_fir_mc.sv - scoreboard bench for nyq_fir_mc with directed vectors
module tb_nyq_fir_mc;
    localparam int NT  = 16;
    localparam int NCH = 3;
    localparam int CB  = 2;
    localparam int AW  = 11;

    typedef struct {
        logic [23:0] d;
        logic [CB-1:0] ch;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [23:0]   par = '0;
    logic [23:0]   din = '0;
    logic [CB-1:0] din_ch = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [23:0]   dout;
    logic [CB-1:0] dout_ch;
    logic          dout_valid;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t e;

    nyq_fir_mc #(
        .IN_WIDTH(24), .COEF_WIDTH(24), .OUT_WIDTH(24), .FRAC_BITS(22),
        .NUM_TAPS(NT), .NUM_CH(NCH), .ADDR_WIDTH(AW), .CH_BITS(CB)
    ) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .WrEn_SI(wr_en), .Addr_DI(addr),
        .PAR_In_DI(par), .In_DI(din), .InCh_DI(din_ch), .InValid_SI(din_valid),
        .InReady_SO(din_ready), .Out_DO(dout), .OutCh_DO(dout_ch), .OutValid_SO(dout_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%0h ch=%0d required=none (cycle %0d)", dout, dout_ch, cyc);
            end else begin
                e = sbq.pop_front();
                chk("out_data", 64'(dout), 64'(e.d));
                chk("out_ch", 64'(dout_ch), 64'(e.ch));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) chk("ready_timeout", 64'(din_ready), 64'd1);
    endtask

    task automatic send(input int ch, input logic [23:0] x, input logic push, input logic [23:0] ed);
        wait_idle();
        din = x;
        din_ch = CB'(ch);
        din_valid = 1'b1;
        if (push) sbq.push_back('{ed, CB'(ch), cyc + 1 + NT + 2});
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [23:0] v);
        @(negedge clk);
        wr_en = 1'b1;
        addr = a;
        par = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic flush_lines();
        wait_idle();
        wr('1, 24'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out", 64'(dout), 64'd0);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_ready", 64'(din_ready), 64'd1);

        // Coefficients are zero out of reset
        send(0, 24'h400000, 1'b1, 24'd0);

        for (int k = 0; k < NT; k++) begin
            wait_idle();
            wr(AW'(k), 24'((k + 1) * 1000));
        end
        flush_lines();
        send(0, 24'h400000, 1'b1, 24'd1000);
        for (int i = 1; i <= NT; i++)
            send(0, 24'd0, 1'b1, (i < NT) ? 24'((i + 1) * 1000) : 24'd0);

        // Interleaved channels, then an out-of-range channel that must not disturb ch0
        flush_lines();
        for (int i = 0; i < 8; i++) begin
            send(0, (i == 0) ? 24'h400000 : 24'd0, 1'b1, 24'((i + 1) * 1000));
            send(1, 24'd0, 1'b1, 24'd0);
        end
        send(3, 24'h400000, 1'b0, 24'd0);
        send(0, 24'd0, 1'b1, 24'd9000);

        for (int k = 0; k < NT; k++) begin
            wait_idle();
            wr(AW'(k), (k == 0) ? 24'd1 : 24'd0);
        end
        flush_lines();
        send(0, 24'h200000, 1'b1, 24'd1);
        send(0, 24'hE00000, 1'b1, 24'd0);

        for (int k = 0; k < NT; k++) begin
            wait_idle();
            wr(AW'(k), 24'h3FFFFF);
        end
        flush_lines();
        for (int i = 0; i < NT; i++)
            send(0, 24'h7FFFFF, 1'b1, (i == 0) ? 24'h7FFFFD : 24'h7FFFFF);
        flush_lines();
        for (int i = 0; i < NT; i++)
            send(0, 24'h800000, 1'b1, (i == 0) ? 24'h800002 : 24'h800000);

        // A write landing during MAC is dropped
        for (int k = 0; k < NT; k++) begin
            wait_idle();
            wr(AW'(k), 24'((k + 1) * 1000));
        end
        flush_lines();
        send(0, 24'h400000, 1'b1, 24'd1000);
        wr(AW'(0), 24'd5000);
        send(0, 24'h400000, 1'b1, 24'd3000);

        flush_lines();
        send(0, 24'h400000, 1'b1, 24'd1000);
        drain();

        // Reset five cycles into a computation
        send(0, 24'h400000, 1'b0, 24'd0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out", 64'(dout), 64'd0);
        chk("midrst_valid", 64'(dout_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(din_ready), 64'd1);
        repeat (30) @(negedge clk);
        send(0, 24'h400000, 1'b1, 24'd0);
        drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nyq_fir_mc.md
Name: nyq_fir_mc

Overview:
Parametrised, multi-channel successor to the single-channel Nyquist filter block. It is a time-multiplexed FIR with a single multiply-accumulate unit and a writable coefficient memory. It keeps one independent delay line per channel and uses a valid/ready input handshake and a valid-qualified output. It sits between the symbol mapper and the DAC interface, and one instance serves the I and Q channels (NUM_CH=2).

Parameters:
IN_WIDTH, 24, signed input sample width
COEF_WIDTH, 24, signed coefficient width
OUT_WIDTH, 24, signed output width
FRAC_BITS, 22, coefficient fractional bits; result is shifted right by this amount
NUM_TAPS, 16, filter length (>=2)
NUM_CH, 2, number of independent channels (>=1)
ADDR_WIDTH, 11, coefficient write address width
CH_BITS, 1, channel index width, ceil(log2(NUM_CH)) with minimum 1
ACC_WIDTH, IN_WIDTH+COEF_WIDTH+log2(NUM_TAPS), internal accumulator width (derived)

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
WrEn_SI  in  1  coefficient write strobe
Addr_DI  in  ADDR_WIDTH  coefficient index or command address
PAR_In_DI  in  COEF_WIDTH  coefficient write data, signed
In_DI  in  IN_WIDTH  input sample, signed
InCh_DI  in  CH_BITS  channel of the input sample
InValid_SI  in  1  input sample valid
InReady_SO  out  1  block can accept a sample
Out_DO  out  OUT_WIDTH  filtered sample, signed
OutCh_DO  out  CH_BITS  channel of Out_DO
OutValid_SO  out  1  one-cycle pulse marking a new Out_DO

Behaviour:
- Reset (asynchronous, Rst_RBI=0): all coefficients, all delay lines and the accumulator clear to 0. Out_DO=0, OutCh_DO=0, OutValid_SO=0. FSM goes to IDLE. InReady_SO=1 once reset is released.
- FSM states: IDLE -> MAC -> ROUND -> OUT -> IDLE.
  - IDLE: InReady_SO=1. A sample is accepted when InValid_SI && InReady_SO. On acceptance, x[ch][0]=In_DI, x[ch][k]=x[ch][k-1] for the other taps, the channel is latched, acc=0, and the FSM moves to MAC.
  - MAC: runs for NUM_TAPS cycles, k=0..NUM_TAPS-1, acc += x[ch][k]*c[k] as a full-precision signed product. InReady_SO=0.
  - ROUND: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift). r saturates to the signed OUT_WIDTH range, max 2^(OUT_WIDTH-1)-1, min -2^(OUT_WIDTH-1).
  - OUT: Out_DO=r, OutCh_DO=ch, OutValid_SO=1 for exactly this cycle. Next state is IDLE.
- Timing:
  - Latency: a sample accepted on edge N gives OutValid_SO high in the cycle after edge N+NUM_TAPS+2.
  - Maximum throughput is one sample per NUM_TAPS+3 cycles.
  - Out_DO and OutCh_DO hold their value until the next OUT state.
- Channel isolation: only the delay line of the addressed channel shifts. Other channels are untouched.
- Invalid channel (InCh_DI >= NUM_CH): the handshake completes, but the sample is discarded. No delay line changes, no output, and the FSM stays in IDLE.
- Coefficient and command writes:
  - Writes are honoured only in IDLE. A WrEn_SI asserted in any other state is dropped.
  - Addr_DI < NUM_TAPS: c[Addr_DI] <= PAR_In_DI on the clock edge.
  - Addr_DI = all-ones: flush. All delay lines clear; coefficients are kept.
  - Any other address: ignored.
- Simultaneous write and sample acceptance in IDLE: both happen. The MAC for that sample uses the newly written coefficient.
- Reset mid-operation: an in-flight computation is abandoned, no OutValid_SO is produced, and all state returns to reset values immediately.

Test Plan:
- Reset: assert Rst_RBI mid-cycle -> Out_DO=0, OutValid_SO=0, InReady_SO=1 after release; an impulse on ch0 before any writes gives Out_DO=0.
- Impulse response: c[k]=(k+1)*1000, ch0 input x=2^22, then NUM_TAPS zeros on ch0 -> consecutive ch0 outputs are 1000, 2000, ..., 16000, then 0. Each OutValid_SO arrives exactly NUM_TAPS+3 cycles after acceptance.
- Channel isolation: interleave the same impulse on ch0 with constant 0 on ch1 -> ch1 outputs are all 0, ch0 sequence is unchanged, and OutCh_DO matches each source. Then InCh_DI=2 with NUM_CH=2 -> no OutValid_SO.
- Rounding and saturation:
  - c[0]=1, others 0, x=2^21 -> Out_DO=1.
  - x=-2^21 -> Out_DO=0.
  - All c=0x3FFFFF, 16 samples of 0x7FFFFF -> Out_DO=0x7FFFFF.
  - All c=0x3FFFFF, 16 samples of 0x800000 -> Out_DO=0x800000.
- Write and flush rules: WrEn_SI to c[0] during MAC -> no effect on later outputs. A flush (Addr=0x7FF) followed by an impulse -> pre-flush history does not contribute.
- Reset mid-MAC: drop Rst_RBI 5 cycles after acceptance -> no OutValid_SO, and the coefficients read back as 0, so the next impulse output is 0.
